// File: rtl/dl_skid_reg.sv
// Two-entry valid/ready register slice (skid buffer). Every output is taken
// straight from a flop, so the slice breaks both the forward and backward paths.
//
// state | meaning
// ------+------------------------------------------------------------
// EMPTY | nothing held; in_ready=1, out_valid=0
// BUSY  | main holds the head entry; in_ready=1, out_valid=1
// FULL  | main holds the head and skid holds the next; in_ready=0
module dl_skid_reg #(
  parameter int unsigned         NUM_BITS = 1,
  parameter logic [NUM_BITS-1:0] RST_VAL  = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [NUM_BITS-1:0] in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [NUM_BITS-1:0] out_data,
  output logic [1:0]          count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t              state_q, state_nxt;
  logic [NUM_BITS-1:0] main_q, main_nxt;
  logic [NUM_BITS-1:0] skid_q, skid_nxt;
  logic                in_fire;
  logic                out_fire;

  assign in_ready  = (state_q != FULL);
  assign out_valid = (state_q != EMPTY);
  assign out_data  = main_q;
  assign count     = state_q;

  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  always_comb begin
    state_nxt = state_q;
    main_nxt  = main_q;
    skid_nxt  = skid_q;
    case (state_q)
      EMPTY: begin
        if (in_fire) begin
          state_nxt = BUSY;
          main_nxt  = in_data;
        end
      end
      BUSY: begin
        if (in_fire && out_fire) begin
          main_nxt = in_data;
        end else if (in_fire) begin
          state_nxt = FULL;
          skid_nxt  = in_data;
        end else if (out_fire) begin
          state_nxt = EMPTY;
        end
      end
      FULL: begin
        // in_ready is low here, so only the drain side can move
        if (out_fire) begin
          state_nxt = BUSY;
          main_nxt  = skid_q;
        end
      end
      default: state_nxt = EMPTY;
    endcase

    // Flush drops coincident transfers but leaves the data registers as they were
    if (flush) begin
      state_nxt = EMPTY;
      main_nxt  = main_q;
      skid_nxt  = skid_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      main_q  <= RST_VAL;
      skid_q  <= RST_VAL;
    end else begin
      state_q <= state_nxt;
      main_q  <= main_nxt;
      skid_q  <= skid_nxt;
    end
  end

endmodule

// File: tb/tb_dl_skid_reg.sv
// Bench for dl_skid_reg: directed cases plus a randomized run, all checked
// against a queue model of the held entries.
module tb_dl_skid_reg;

  localparam int unsigned     NB   = 32;
  localparam logic [NB-1:0]   RSTV = 32'hDEADBEEF;

  logic          clk;
  logic          rst;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [NB-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [NB-1:0] out_data;
  logic [1:0]    count;

  int            errors = 0;
  int            checks = 0;
  int            n_out  = 0;
  logic [NB-1:0] sb_q[$];

  logic          hold_q = 1'b0;
  logic [NB-1:0] hold_data = '0;

  dl_skid_reg #(.NUM_BITS(NB), .RST_VAL(RSTV)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .count     (count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard / occupancy model, sampled on the falling edge
  always @(negedge clk) begin
    if (rst) begin
      sb_q.delete();
      hold_q = 1'b0;
    end else begin
      check("occupancy", 32'(count), 32'(sb_q.size()));
      check("in_ready_model", 32'(in_ready), 32'(sb_q.size() < 2));
      check("out_valid_model", 32'(out_valid), 32'(sb_q.size() != 0));
      if (sb_q.size() != 0) check("head_data", out_data, sb_q[0]);
      if (hold_q) begin
        check("stable_valid", 32'(out_valid), 32'd1);
        check("stable_data", out_data, hold_data);
      end
      if (flush) begin
        sb_q.delete();
      end else begin
        if (out_valid && out_ready && sb_q.size() != 0) begin
          check("sb_order", out_data, sb_q.pop_front());
          n_out++;
        end
        if (in_valid && in_ready) sb_q.push_back(in_data);
      end
      hold_q    = out_valid && !out_ready && !flush;
      hold_data = out_data;
    end
  end

  initial begin
    logic fired;
    int   cyc;
    int   start_out;

    // Reset with a valid offer that must not be captured
    rst = 1'b1; flush = 1'b0; in_valid = 1'b1; in_data = 32'h5; out_ready = 1'b0;
    step(); step();
    rst = 1'b0; in_valid = 1'b0;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", out_data, RSTV);
    check("rst_count", 32'(count), 32'd0);
    step();
    check("rst_nothing_captured", 32'(count), 32'd0);

    // Streaming 1..8 back-to-back
    out_ready = 1'b1;
    for (int v = 1; v <= 8; v++) begin
      in_valid = 1'b1; in_data = 32'(v);
      step();
      check("stream_data", out_data, 32'(v));
      check("stream_count", 32'(count), 32'd1);
    end
    in_valid = 1'b0;
    step();
    check("stream_drained", 32'(count), 32'd0);

    // Backpressure: A, B fill the slice, C waits
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'hA; step();
    in_data = 32'hB; step();
    check("bp_full_count", 32'(count), 32'd2);
    check("bp_full_in_ready", 32'(in_ready), 32'd0);
    in_data = 32'hC; step();
    check("bp_c_held_count", 32'(count), 32'd2);
    check("bp_head_a", out_data, 32'hA);
    out_ready = 1'b1; step();
    check("bp_head_b", out_data, 32'hB);
    check("bp_count_after_a", 32'(count), 32'd1);
    step();
    check("bp_head_c", out_data, 32'hC);
    in_valid = 1'b0; step();
    check("bp_drained", 32'(count), 32'd0);

    // Simultaneous in/out fire in BUSY
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h3; step();
    check("sim_head_3", out_data, 32'h3);
    in_data = 32'h4; out_ready = 1'b1; step();
    check("sim_count", 32'(count), 32'd1);
    check("sim_head_4", out_data, 32'h4);
    in_valid = 1'b0; step();

    // Flush while FULL with a concurrent offer
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h11; step();
    in_data = 32'h22; step();
    check("fl_full", 32'(count), 32'd2);
    in_data = 32'h33; flush = 1'b1; step();
    flush = 1'b0; in_valid = 1'b0;
    check("fl_count", 32'(count), 32'd0);
    check("fl_out_valid", 32'(out_valid), 32'd0);
    check("fl_in_ready", 32'(in_ready), 32'd1);
    step();
    check("fl_still_empty", 32'(count), 32'd0);
    // Flush in BUSY with coincident in_fire and out_fire
    in_valid = 1'b1; in_data = 32'h55; step();
    in_data = 32'h66; out_ready = 1'b1; flush = 1'b1; step();
    flush = 1'b0; in_valid = 1'b0;
    check("fl_busy_count", 32'(count), 32'd0);
    in_valid = 1'b1; in_data = 32'h44; step();
    in_valid = 1'b0;
    check("fl_next_data", out_data, 32'h44);
    step();

    // Random traffic, 10k transfers
    start_out = n_out;
    cyc = 0;
    in_valid = 1'b0;
    while ((n_out - start_out) < 10000 && cyc < 60000) begin
      fired = in_valid && in_ready;
      if (!in_valid || fired) begin
        in_valid = 1'($urandom_range(0, 1));
        in_data  = $urandom;
      end
      out_ready = 1'($urandom_range(0, 1));
      step();
      cyc++;
    end
    check("rand_transfers_done", 32'((n_out - start_out) >= 10000), 32'd1);
    in_valid = 1'b0; out_ready = 1'b1;
    step(); step(); step();
    check("rand_drained", 32'(count), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
